// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the memory port shared by mem_port_arbiter.
// The arbiter uses the slave modport; the environment (requesters + memory) uses master.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Requester side: req is held with we/addr/wdata until the one-cycle ready pulse,
  // and must drop in the ready cycle or a new access is taken immediately.
  // Memory side: en stays high until a one-cycle ack (any latency) or an abort.
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic [DW-1:0] ext_rdata;
  logic          ext_ready;

  logic          err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_rdata, ext_ready,
    output err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_rdata, ext_ready,
    input  err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port: CPU priority with a bounded
// run while EXT waits, en/ack memory sequencing and a watchdog abort.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 15,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic                 dbg_state
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_CPU_RUN + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state, state_nxt;
  logic          owner_ext;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] run_cnt;
  logic [DW-1:0] cpu_rdata_q, ext_rdata_q;
  logic          cpu_ready_q, ext_ready_q, err_q;

  logic          grant, grant_ext, done_ok, done_abort;
  logic [DW-1:0] rd_val;

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_ext  = 1'b0;
    done_ok    = 1'b0;
    done_abort = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req || bus.ext_req) begin
          grant     = 1'b1;
          // EXT only overtakes a requesting CPU once the CPU has used up its run.
          grant_ext = bus.ext_req && (!bus.cpu_req || run_cnt == RW'(MAX_CPU_RUN));
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          done_abort = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_val = done_ok ? bus.mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner_ext   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      tmo_cnt     <= '0;
      run_cnt     <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      ext_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      cpu_ready_q <= 1'b0;
      ext_ready_q <= 1'b0;
      err_q       <= 1'b0;
      if (grant) begin
        owner_ext <= grant_ext;
        r_we      <= grant_ext ? bus.ext_we    : bus.cpu_we;
        r_addr    <= grant_ext ? bus.ext_addr  : bus.cpu_addr;
        r_wdata   <= grant_ext ? bus.ext_wdata : bus.cpu_wdata;
        tmo_cnt   <= '0;
        if (grant_ext || !bus.ext_req) begin
          run_cnt <= '0;
        end else if (run_cnt != RW'(MAX_CPU_RUN)) begin
          run_cnt <= run_cnt + 1'b1;
        end
      end
      if (state == ACCESS && !bus.mem_ack) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (done_ok || done_abort) begin
        cpu_ready_q <= !owner_ext;
        ext_ready_q <= owner_ext;
        err_q       <= done_abort;
        // Writes leave the owner's read data untouched, aborted or not.
        if (!r_we) begin
          if (owner_ext) ext_rdata_q <= rd_val;
          else           cpu_rdata_q <= rd_val;
        end
      end
    end
  end

  assign bus.mem_en    = (state == ACCESS);
  assign bus.mem_we    = (state == ACCESS) && r_we;
  assign bus.mem_addr  = (state == ACCESS) ? r_addr  : '0;
  assign bus.mem_wdata = (state == ACCESS) ? r_wdata : '0;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ext_rdata = ext_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.ext_ready = ext_ready_q;
  assign bus.err       = err_q;
  assign dbg_state     = (state == ACCESS);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// random requesters and memory latency checked against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW          = 32;
  localparam int DW          = 32;
  localparam int TIMEOUT     = 15;
  localparam int MAX_CPU_RUN = 4;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_CPU_RUN(MAX_CPU_RUN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // One outstanding access record; age counts ack-less cycles spent on it.
  bit            m_busy, m_ext, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_age, m_streak;
  bit            e_cpu_ready, e_ext_ready, e_err;
  logic [DW-1:0] e_cpu_rdata, e_ext_rdata;
  bit            grant_q[$];
  logic [AW+DW:0] exp_q[$];
  bit            prev_en;

  task automatic model_step();
    bit take_ext, finish, aborted;
    e_cpu_ready = 1'b0;
    e_ext_ready = 1'b0;
    e_err       = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_streak = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
      e_cpu_rdata = '0; e_ext_rdata = '0;
      return;
    end
    if (m_busy) begin
      finish = 1'b0; aborted = 1'b0;
      if (bus.mem_ack) finish = 1'b1;
      else begin
        m_age++;
        if (m_age >= TIMEOUT) begin finish = 1'b1; aborted = 1'b1; end
      end
      if (finish) begin
        m_busy = 1'b0;
        e_err  = aborted;
        if (m_ext) e_ext_ready = 1'b1; else e_cpu_ready = 1'b1;
        if (!m_we) begin
          if (m_ext) e_ext_rdata = aborted ? '0 : bus.mem_rdata;
          else       e_cpu_rdata = aborted ? '0 : bus.mem_rdata;
        end
      end
    end else if (bus.cpu_req || bus.ext_req) begin
      take_ext = bus.ext_req && !(bus.cpu_req && m_streak < MAX_CPU_RUN);
      m_busy  = 1'b1;
      m_age   = 0;
      m_ext   = take_ext;
      m_we    = take_ext ? bus.ext_we    : bus.cpu_we;
      m_addr  = take_ext ? bus.ext_addr  : bus.cpu_addr;
      m_wdata = take_ext ? bus.ext_wdata : bus.cpu_wdata;
      if (!take_ext && bus.ext_req) m_streak = (m_streak < MAX_CPU_RUN) ? m_streak + 1 : MAX_CPU_RUN;
      else m_streak = 0;
      grant_q.push_back(take_ext);
      exp_q.push_back({m_we, m_addr, m_wdata});
    end
  endtask

  task automatic compare_step();
    check("mem_en",    bus.mem_en,    m_busy);
    check("mem_we",    bus.mem_we,    m_busy & m_we);
    check("mem_addr",  bus.mem_addr,  m_busy ? m_addr  : '0);
    check("mem_wdata", bus.mem_wdata, m_busy ? m_wdata : '0);
    check("cpu_ready", bus.cpu_ready, e_cpu_ready);
    check("ext_ready", bus.ext_ready, e_ext_ready);
    check("err",       bus.err,       e_err);
    check("cpu_rdata", bus.cpu_rdata, e_cpu_rdata);
    check("ext_rdata", bus.ext_rdata, e_ext_rdata);
    check("dbg_state", dbg_state,     m_busy);
    if (bus.mem_en && !prev_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL access_start: got unexpected access at %0t required none", $time);
      end else begin
        check("access_ops", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, exp_q.pop_front());
      end
    end
    prev_en = bus.mem_en;
  endtask

  initial begin
    prev_en = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_step();
    end
  end

  // ---------------- drivers ----------------
  int            resp_mode;   // 0 random, 1 fixed latency, 2 manual
  int            fixed_lat;
  logic [DW-1:0] fixed_rdata;
  int            r_age, r_lat;
  bit            req_auto;

  function automatic int pick_lat();
    int v;
    v = $urandom_range(0, 99);
    if (v < 70) return $urandom_range(0, 4);
    if (v < 85) return $urandom_range(12, 14);
    return 30;
  endfunction

  task automatic respond_step();
    if (resp_mode == 2) return;
    if (bus.mem_en) begin
      if (resp_mode == 1) r_lat = fixed_lat;
      else if (r_age == 0) r_lat = pick_lat();
      bus.mem_ack   = (r_age == r_lat);
      bus.mem_rdata = (resp_mode == 1) ? fixed_rdata : DW'($urandom());
      r_age++;
    end else begin
      r_age         = 0;
      bus.mem_ack   = (resp_mode == 0) && ($urandom_range(0, 9) == 0);
      bus.mem_rdata = DW'($urandom());
    end
  endtask

  task automatic req_step();
    if (!req_auto) return;
    if (bus.cpu_req) begin
      if (bus.cpu_ready) bus.cpu_req = ($urandom_range(0, 7) == 0);
      else if ($urandom_range(0, 29) == 0) begin
        bus.cpu_we = 1'($urandom_range(0, 1)); bus.cpu_addr = AW'($urandom()); bus.cpu_wdata = DW'($urandom());
      end else if ($urandom_range(0, 59) == 0) bus.cpu_req = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      bus.cpu_req = 1'b1; bus.cpu_we = 1'($urandom_range(0, 1));
      bus.cpu_addr = AW'($urandom()); bus.cpu_wdata = DW'($urandom());
    end
    if (bus.ext_req) begin
      if (bus.ext_ready) bus.ext_req = ($urandom_range(0, 7) == 0);
      else if ($urandom_range(0, 29) == 0) begin
        bus.ext_we = 1'($urandom_range(0, 1)); bus.ext_addr = AW'($urandom()); bus.ext_wdata = DW'($urandom());
      end else if ($urandom_range(0, 59) == 0) bus.ext_req = 1'b0;
    end else if ($urandom_range(0, 4) == 0) begin
      bus.ext_req = 1'b1; bus.ext_we = 1'($urandom_range(0, 1));
      bus.ext_addr = AW'($urandom()); bus.ext_wdata = DW'($urandom());
    end
  endtask

  task automatic tick();
    @(negedge clk);
    respond_step();
    req_step();
  endtask

  // ---------------- directed + random sequence ----------------
  int cyc, cnt, g0, n_g;
  bit ok;
  bit got[10];
  bit exp_pat[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1;
    resp_mode = 2; fixed_lat = 0; fixed_rdata = '0; r_age = 0; r_lat = 0; req_auto = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0040; bus.cpu_wdata = '0;
    bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;

    // Reset held two cycles with a CPU request pending
    repeat (2) tick();
    check("t1_reset_mem_en",    bus.mem_en,    1'b0);
    check("t1_reset_cpu_ready", bus.cpu_ready, 1'b0);
    check("t1_reset_err",       bus.err,       1'b0);
    check("t1_reset_cpu_rdata", bus.cpu_rdata, 32'h0);
    rst = 1'b0;
    resp_mode = 1; fixed_lat = 3; fixed_rdata = 32'h8C01_0004;
    tick();
    check("t1_mem_en_2nd_cycle", bus.mem_en, 1'b1);

    // CPU read with ack three cycles after mem_en
    cyc = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(); cyc++;
      if (bus.cpu_ready) ok = 1'b1;
    end
    check("t2_ready_seen", ok, 1'b1);
    check("t2_latency",    cyc, 4);
    check("t2_cpu_rdata",  bus.cpu_rdata, 32'h8C01_0004);
    check("t2_ext_ready",  bus.ext_ready, 1'b0);
    check("t2_err",        bus.err, 1'b0);
    bus.cpu_req = 1'b0;

    // EXT write, ack in the first access cycle
    tick();
    fixed_lat = 0;
    bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_addr = 32'h100; bus.ext_wdata = 32'hDEAD_BEEF;
    tick();
    check("t3_mem_en",    bus.mem_en,    1'b1);
    check("t3_mem_we",    bus.mem_we,    1'b1);
    check("t3_mem_addr",  bus.mem_addr,  32'h100);
    check("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    tick();
    check("t3_ext_ready", bus.ext_ready, 1'b1);
    check("t3_err",       bus.err,       1'b0);
    check("t3_cpu_rdata", bus.cpu_rdata, 32'h8C01_0004);
    check("t3_ext_rdata", bus.ext_rdata, 32'h0);
    bus.ext_req = 1'b0;

    // Both requesters held continuously: fairness pattern
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h200;
    bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h300;
    g0 = grant_q.size(); n_g = 0;
    for (int i = 0; i < 80 && n_g < 10; i++) begin
      tick();
      if (bus.mem_en) begin
        got[n_g] = (bus.mem_addr == 32'h300);
        n_g++;
      end
    end
    bus.cpu_req = 1'b0; bus.ext_req = 1'b0;
    check("t4_grant_count", n_g, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4_dut_grant_%0d", i), got[i], exp_pat[i]);
      if (grant_q.size() > g0 + i) check($sformatf("t4_model_grant_%0d", i), grant_q[g0 + i], exp_pat[i]);
    end
    repeat (2) tick();

    // Watchdog: no ack ever, then ack exactly on the limit cycle
    fixed_lat = 99;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h44;
    cnt = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (bus.mem_en) cnt++;
      if (bus.cpu_ready) ok = 1'b1;
    end
    bus.cpu_req = 1'b0;
    check("t5_abort_ready",  ok, 1'b1);
    check("t5_abort_en_len", cnt, 15);
    check("t5_abort_err",    bus.err, 1'b1);
    check("t5_abort_rdata",  bus.cpu_rdata, 32'h0);
    tick();
    fixed_lat = 14; fixed_rdata = 32'h1234_5678;
    bus.cpu_req = 1'b1;
    cnt = 0; ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (bus.mem_en) cnt++;
      if (bus.cpu_ready) ok = 1'b1;
    end
    bus.cpu_req = 1'b0;
    check("t5_lastack_ready",  ok, 1'b1);
    check("t5_lastack_en_len", cnt, 15);
    check("t5_lastack_err",    bus.err, 1'b0);
    check("t5_lastack_rdata",  bus.cpu_rdata, 32'h1234_5678);

    // Reset in the middle of an access, then a late ack
    tick();
    fixed_lat = 99;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h48;
    repeat (4) tick();
    check("t6_in_access", bus.mem_en, 1'b1);
    rst = 1'b1; bus.cpu_req = 1'b0;
    tick();
    check("t6_rst_mem_en", bus.mem_en,    1'b0);
    check("t6_rst_ready",  bus.cpu_ready, 1'b0);
    rst = 1'b0;
    resp_mode = 2; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_ack = 1'b0;
    check("t6_late_ready", bus.cpu_ready, 1'b0);
    check("t6_late_mem_en", bus.mem_en,   1'b0);
    tick();
    check("t6_late_ready2", bus.cpu_ready, 1'b0);
    check("t6_late_err",    bus.err,       1'b0);

    // Random traffic with occasional resets
    resp_mode = 0; r_age = 0; req_auto = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0; req_auto = 1'b0;
    bus.cpu_req = 1'b0; bus.ext_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (!m_busy && !bus.mem_en) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL drain: got busy after 100 cycles required idle");
    end
    repeat (3) tick();
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
